// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding for the one-hot scan decoder
// Purpose: state enum used by onehot_scan_decoder.
// Ports: none (package).
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_decode.sv
// rtl/onehot_decode.sv - combinational N-to-2^N one-hot decoder with enable
// Purpose: decode idx to a one-hot vector; disabled output is all ones.
// Ports:
//   en   - 1 = decode idx, 0 = drive all ones
//   idx  - SEL_W-bit index to decode
//   dec  - 2**SEL_W-bit decoded pattern
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        idx,
  output logic [(2**SEL_W)-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (!en) begin
      dec = '1;
    end else begin
      dec[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - one-hot decoder with direct and auto-scan modes
// Purpose: drives a registered one-hot output either from sel (direct) or from
//          a self-advancing index that dwells dwell+1 cycles per position (scan).
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - synchronous active-high reset
//   en       - 0 forces idle (out all ones)
//   mode     - 0 = direct decode, 1 = auto-scan
//   sel      - direct index / scan start index
//   dwell    - extra hold cycles per scan index (sampled live)
//   out      - registered one-hot output, all ones when idle
//   cur_idx  - registered index currently shown on out
//   wrap     - one-cycle pulse when scan index rolls to 0
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(2**SEL_W)-1:0]  out,
  output logic [SEL_W-1:0]       cur_idx,
  output logic                   wrap
);

  localparam int OUTS = 2**SEL_W;

  state_t              state;
  logic [DWELL_W-1:0]  cnt;

  state_t              nxt_state;
  logic [SEL_W-1:0]    nxt_idx;
  logic [DWELL_W-1:0]  nxt_cnt;
  logic                nxt_wrap;
  logic [OUTS-1:0]     nxt_out;

  // Next-state is recomputed every cycle from en/mode; en has priority over
  // any pending scan advance.
  always_comb begin
    nxt_state = ST_IDLE;
    nxt_idx   = '0;
    nxt_cnt   = '0;
    nxt_wrap  = 1'b0;
    if (en) begin
      if (!mode) begin
        nxt_state = ST_DIRECT;
        nxt_idx   = sel;
      end else if (state != ST_SCAN) begin
        // Scan entry: start from sel with a fresh dwell count.
        nxt_state = ST_SCAN;
        nxt_idx   = sel;
      end else if (cnt >= dwell) begin
        // >= (not ==) so a live decrease of dwell below cnt advances at once
        // instead of letting cnt run up to overflow.
        nxt_state = ST_SCAN;
        nxt_idx   = cur_idx + 1'b1;
        nxt_wrap  = &cur_idx;
      end else begin
        nxt_state = ST_SCAN;
        nxt_idx   = cur_idx;
        nxt_cnt   = cnt + 1'b1;
      end
    end
  end

  // Decode the next index so out lands in the same flop stage as cur_idx.
  onehot_decode #(
    .SEL_W (SEL_W)
  ) u_decode (
    .en  (nxt_state != ST_IDLE),
    .idx (nxt_idx),
    .dec (nxt_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      wrap    <= 1'b0;
      out     <= '1;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      cur_idx <= nxt_idx;
      wrap    <= nxt_wrap;
      out     <= nxt_out;
    end
  end

endmodule

// File: doc/onehot_scan_decoder.md
ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001: SHALL have parameter SEL_W, default 3, select width; output count OUTS = 2**SEL_W (derived, not overridable).
REQ-002: SHALL have parameter DWELL_W, default 8, width of the scan dwell count.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: en  input  1  enable; 0 forces the idle output pattern.
REQ-006: mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007: sel  input  SEL_W  index to decode in direct mode; start index on scan entry.
REQ-008: dwell  input  DWELL_W  extra cycles each index is held in scan mode.
REQ-009: out  output  OUTS  registered one-hot output; all ones when idle.
REQ-010: cur_idx  output  SEL_W  registered index currently driven on out.
REQ-011: wrap  output  1  one-cycle pulse when the scan index rolls from OUTS-1 to 0.

Function
REQ-012: SHALL implement three states: IDLE, DIRECT, SCAN.
REQ-013: Next-state selection SHALL be evaluated every cycle: en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-014: In IDLE, out SHALL be all ones, cur_idx 0, dwell counter 0, wrap 0.
REQ-015: In DIRECT, out SHALL equal the one-hot decode of sel (bit sel set, all others 0), cur_idx = sel, with exactly one clock of latency from sel to out.
REQ-016: On entry to SCAN from IDLE or DIRECT, cur_idx SHALL load sel and the dwell counter SHALL clear; out SHALL be the one-hot decode of sel on the first SCAN cycle.
REQ-017: In SCAN, the dwell counter SHALL increment each cycle while its value is less than dwell; when counter >= dwell, the next cycle SHALL advance cur_idx by 1 and clear the counter.
REQ-018: Each index SHALL therefore be held for dwell+1 cycles; dwell=0 SHALL advance every cycle.
REQ-019: dwell SHALL be sampled live; lowering it below the current count SHALL cause advance on the next cycle and never a counter overflow.
REQ-020: Index advance from OUTS-1 SHALL wrap to 0 and assert wrap for exactly the one cycle in which cur_idx = 0 first appears; wrap SHALL be 0 at all other times and in IDLE/DIRECT.
REQ-021: sel changes during SCAN SHALL be ignored.
REQ-022: out SHALL always be either all ones (IDLE) or exactly one-hot, never any other pattern, and SHALL always equal the decode of cur_idx outside IDLE.
REQ-023: Simultaneous en fall and scan advance SHALL yield IDLE (en has priority).

Reset
REQ-024: rst=1 at a clock edge SHALL force state IDLE, out all ones, cur_idx 0, dwell counter 0, wrap 0, overriding all other inputs.
REQ-025: rst asserted mid-scan SHALL abandon the scan; after release with en=1, mode=1, scan SHALL restart from the then-current sel.

Structure
REQ-026: State enum (IDLE, DIRECT, SCAN) SHALL reside in shared package decoder_pkg.
REQ-027: The N-to-2^N one-hot decode with enable (disabled = all ones) SHALL be one combinational sub-module, onehot_decode, parametrised by SEL_W, instanced once.
REQ-028: All outputs SHALL be driven directly from flops.

Verification
REQ-029: Reset: rst=1 for 2 cycles, en=1, mode=1 -> out=8'hFF, cur_idx=0, wrap=0.
REQ-030: Direct: en=1, mode=0, sel=5 -> next cycle out=8'b0010_0000, cur_idx=5; sel=0 -> next cycle out=8'h01.
REQ-031: Scan dwell=2 from sel=6 -> out=8'h40 for 3 cycles, 8'h80 for 3 cycles, then 8'h01 with wrap=1 for one cycle only.
REQ-032: Scan dwell=0 from sel=0 -> out walks 01,02,04,...,80,01 one per cycle; wrap pulses every 8 cycles.
REQ-033: Mid-scan with counter=5 of dwell=9, drop dwell to 1 -> index advances next cycle; then holds 2 cycles per index.
REQ-034: en=0 mid-scan -> next cycle out=8'hFF, cur_idx=0; rst mid-scan then release with sel=3 -> out=8'h08 first scan cycle.
